// File: rtl/gcd_arb_pkg.sv
`default_nettype none
//============================================================================
// Module : gcd_arb_pkg
// Brief  : Shared types and helpers for the round-robin GCD core arbiter.
// Rev    : 1.0  initial release
//============================================================================
package gcd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam int c_MAX_REQ  = 16;
    localparam int c_MAX_ID_W = 4;

    function automatic int id_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

    // Returns {found, index}: first set request at or after ptr, wrapping at n_req.
    function automatic logic [c_MAX_ID_W:0] rr_winner(
        input logic [c_MAX_REQ-1:0]  req,
        input logic [c_MAX_ID_W-1:0] ptr,
        input int                    n_req
    );
        logic                  found;
        logic [c_MAX_ID_W-1:0] idx;
        logic [c_MAX_ID_W:0]   j;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < c_MAX_REQ; i++) begin
            j = {1'b0, ptr} + (c_MAX_ID_W + 1)'(i);
            if (j >= (c_MAX_ID_W + 1)'(n_req)) begin
                j = j - (c_MAX_ID_W + 1)'(n_req);
            end
            if ((i < n_req) && !found && req[j[c_MAX_ID_W-1:0]]) begin
                found = 1'b1;
                idx   = j[c_MAX_ID_W-1:0];
            end
        end
        return {found, idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/gcd_rr_arbiter_pick.sv
`default_nettype none
//============================================================================
// Module : gcd_rr_pick
// Brief  : Combinational round-robin picker (request vector + pointer -> index).
// Rev    : 1.0  initial release
//============================================================================
module gcd_rr_pick
    import gcd_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    logic [c_MAX_REQ-1:0]  w_req_ext;
    logic [c_MAX_ID_W-1:0] w_ptr_ext;
    logic [c_MAX_ID_W:0]   w_win;

    always_comb begin
        w_req_ext = c_MAX_REQ'(req);
        w_ptr_ext = c_MAX_ID_W'(ptr);
        w_win     = rr_winner(w_req_ext, w_ptr_ext, N_REQ);
    end

    assign found = w_win[c_MAX_ID_W];
    assign idx   = ID_W'(w_win[c_MAX_ID_W-1:0]);

endmodule
`default_nettype wire

// File: rtl/gcd_rr_arbiter.sv
`default_nettype none
//============================================================================
// Module : gcd_rr_arbiter
// Brief  : Round-robin sharing of one GCD core among N_REQ requesters.
//          Optional macro GCD_ARB_ZERO_BYPASS_EN answers zero-operand jobs
//          directly without starting the core.
// Rev    : 1.0  initial release
//============================================================================
module gcd_rr_arbiter
    import gcd_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int OP_SZ = 8,
    parameter int ID_W  = id_width(N_REQ)   // derived; do not override
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*OP_SZ-1:0] a_in,
    input  logic [N_REQ*OP_SZ-1:0] b_in,
    output logic [N_REQ-1:0]   gnt,
    output logic               rsp_valid,
    output logic [ID_W-1:0]    rsp_id,
    output logic [OP_SZ-1:0]   rsp_data,
    output logic               busy,
    output logic               gcd_start,
    output logic [OP_SZ-1:0]   gcd_a,
    output logic [OP_SZ-1:0]   gcd_b,
    input  logic               gcd_done,
    input  logic [OP_SZ-1:0]   gcd_res
);

    arb_state_t        r_state, w_state_nxt;
    logic [ID_W-1:0]   r_ptr, r_id;
    logic [N_REQ-1:0]  r_gnt;
    logic              r_rsp_valid, r_busy, r_gcd_start;
    logic [ID_W-1:0]   r_rsp_id;
    logic [OP_SZ-1:0]  r_rsp_data, r_gcd_a, r_gcd_b;

    logic              w_found, w_bypass, w_take;
    logic [ID_W-1:0]   w_idx, w_rsp_id, w_ptr_nxt;
    logic [OP_SZ-1:0]  w_a, w_b, w_rsp_data;
    logic [N_REQ-1:0]  w_onehot;

    gcd_rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    assign w_a = a_in[int'(w_idx)*OP_SZ +: OP_SZ];
    assign w_b = b_in[int'(w_idx)*OP_SZ +: OP_SZ];

    always_comb begin
        w_take   = (r_state == ST_IDLE) && w_found;
        w_onehot = N_REQ'(1) << w_idx;
`ifdef GCD_ARB_ZERO_BYPASS_EN
        w_bypass = (w_a == '0) || (w_b == '0);
`else
        w_bypass = 1'b0;
`endif
        // A bypassed job reaches RESP straight from IDLE, so id/data come from the picker.
        w_rsp_id   = (r_state == ST_IDLE) ? w_idx : r_id;
        w_rsp_data = (r_state == ST_IDLE) ? (w_a | w_b) : gcd_res;
        w_ptr_nxt  = (w_rsp_id == ID_W'(N_REQ - 1)) ? '0 : w_rsp_id + ID_W'(1);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_found) w_state_nxt = w_bypass ? ST_RESP : ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (gcd_done) w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_gnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
            r_busy      <= 1'b0;
            r_gcd_start <= 1'b0;
            r_gcd_a     <= '0;
            r_gcd_b     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gcd_start <= (w_state_nxt == ST_ISSUE);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_rsp_valid <= (w_state_nxt == ST_RESP);
            r_gnt       <= w_take ? w_onehot : '0;
            if (w_take) begin
                r_id <= w_idx;
                if (!w_bypass) begin
                    r_gcd_a <= w_a;
                    r_gcd_b <= w_b;
                end
            end
            if (w_state_nxt == ST_RESP) begin
                r_rsp_id   <= w_rsp_id;
                r_rsp_data <= w_rsp_data;
                r_ptr      <= w_ptr_nxt;
            end
        end
    end

    assign gnt       = r_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign busy      = r_busy;
    assign gcd_start = r_gcd_start;
    assign gcd_a     = r_gcd_a;
    assign gcd_b     = r_gcd_b;

endmodule
`default_nettype wire
